// File: rtl/nc_pkg.sv
// Shared definitions for the neural matrix-vector engine: FSM states, command bytes
// and the signed 8-bit saturation helper.
package nc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        COMPUTE,
        SEND
    } nc_state_e;

    localparam logic [7:0] CMD_LOAD_W = 8'h01;
    localparam logic [7:0] CMD_LOAD_X = 8'h02;
    localparam logic [7:0] CMD_SEND   = 8'h03;

    // Clamp a signed value into the signed 8-bit range.
    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        logic [7:0] r;
        if (v > 32'sd127) begin
            r = 8'h7f;
        end else if (v < -32'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/nc_mac.sv
// Signed multiply-accumulate with clear, plus the shift / optional ReLU / saturate
// output stage. Macro NC_RELU_EN enables the ReLU.
module nc_mac
    import nc_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int ACC_W = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y_c
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [7:0]       a_s, b_s;
    logic signed [15:0]      prod_c;
    logic signed [ACC_W-1:0] sum_c, shifted_c;
`ifdef NC_RELU_EN
    logic signed [ACC_W-1:0] relu_c;
`endif

    assign a_s = a;
    assign b_s = b;

    // y_c reflects the accumulator including the current product (row-final value).
    always_comb begin
        prod_c    = a_s * b_s;
        sum_c     = acc_q + ACC_W'(prod_c);
        shifted_c = sum_c >>> SHIFT;
`ifdef NC_RELU_EN
        relu_c    = (shifted_c < 0) ? '0 : shifted_c;
        y_c       = sat8(32'(relu_c));
`else
        y_c       = sat8(32'(shifted_c));
`endif
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/nc_mvm_engine.sv
// Byte-stream driven DIM x DIM signed matrix-vector engine with ready/valid result port.
// Macro NC_RELU_EN (in nc_mac) clamps negative results to zero.
module nc_mvm_engine
    import nc_pkg::*;
#(
    parameter int DIM   = 2,
    parameter int SHIFT = 0,
    parameter int ACC_W = 16 + $clog2(DIM) + 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY,
    output logic       LOAD_ARR,
    output logic       MULT_DONE,
    output logic       BUSY,
    output logic       OVERRUN
);

    localparam int unsigned XW    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM * DIM) : 1;
    localparam int unsigned XN    = 1 << XW;
    localparam int unsigned WN    = 1 << IDX_W;

    nc_state_e        state_q, state_d;
    logic [IDX_W-1:0] ld_q, ld_d;
    logic [XW-1:0]    r_q, r_d, c_q, c_d;
    logic [7:0]       w_q [WN];
    logic [7:0]       w_d [WN];
    logic [7:0]       x_q [XN];
    logic [7:0]       x_d [XN];
    logic [7:0]       y_q [XN];
    logic [7:0]       y_d [XN];
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             load_arr_q, load_arr_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             mac_en_c, mac_clr_c;
    logic [7:0]       mac_y_c;
    logic [IDX_W-1:0] w_idx_c;

    assign w_idx_c = IDX_W'(r_q) * IDX_W'(DIM) + IDX_W'(c_q);

    nc_mac #(
        .SHIFT(SHIFT),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk  (CLK),
        .reset(RESET),
        .en   (mac_en_c),
        .clr  (mac_clr_c),
        .a    (w_q[w_idx_c]),
        .b    (x_q[c_q]),
        .y_c  (mac_y_c)
    );

    always_comb begin
        state_d    = state_q;
        ld_d       = ld_q;
        r_d        = r_q;
        c_d        = c_q;
        w_d        = w_q;
        x_d        = x_q;
        y_d        = y_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        ovr_d      = ovr_q;
        mac_en_c   = 1'b0;
        mac_clr_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_VALID) begin
                    case (RX_DATA)
                        CMD_LOAD_W: begin
                            state_d = LOAD_W;
                            ld_d    = '0;
                            ovr_d   = 1'b0;
                        end
                        CMD_LOAD_X: begin
                            state_d = LOAD_X;
                            ld_d    = '0;
                            ovr_d   = 1'b0;
                        end
                        CMD_SEND: begin
                            state_d    = SEND;
                            r_d        = '0;
                            tx_valid_d = 1'b1;
                            tx_data_d  = y_q[XW'(0)];
                            ovr_d      = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD_W: begin
                if (RX_VALID) begin
                    w_d[ld_q] = RX_DATA;
                    if (ld_q == IDX_W'(DIM * DIM - 1)) begin
                        state_d = IDLE;
                        ld_d    = '0;
                    end else begin
                        ld_d = ld_q + IDX_W'(1);
                    end
                end
            end
            LOAD_X: begin
                if (RX_VALID) begin
                    x_d[XW'(ld_q)] = RX_DATA;
                    if (ld_q == IDX_W'(DIM - 1)) begin
                        state_d = COMPUTE;
                        ld_d    = '0;
                        r_d     = '0;
                        c_d     = '0;
                    end else begin
                        ld_d = ld_q + IDX_W'(1);
                    end
                end
            end
            COMPUTE: begin
                mac_en_c = 1'b1;
                if (RX_VALID) begin
                    ovr_d = 1'b1;
                end
                if (c_q == XW'(DIM - 1)) begin
                    mac_clr_c = 1'b1;
                    y_d[r_q]  = mac_y_c;
                    c_d       = '0;
                    // y_d[0] may have been written this cycle when DIM is 1.
                    if (r_q == XW'(DIM - 1)) begin
                        state_d    = SEND;
                        r_d        = '0;
                        done_d     = 1'b1;
                        tx_valid_d = 1'b1;
                        tx_data_d  = y_d[XW'(0)];
                    end else begin
                        r_d = r_q + XW'(1);
                    end
                end else begin
                    c_d = c_q + XW'(1);
                end
            end
            SEND: begin
                if (RX_VALID) begin
                    ovr_d = 1'b1;
                end
                if (tx_valid_q && TX_READY) begin
                    if (r_q == XW'(DIM - 1)) begin
                        state_d    = IDLE;
                        r_d        = '0;
                        tx_valid_d = 1'b0;
                    end else begin
                        r_d       = r_q + XW'(1);
                        tx_data_d = y_q[r_q + XW'(1)];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        load_arr_d = (state_d == LOAD_W) || (state_d == LOAD_X);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            ld_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            w_q        <= '{default: '0};
            x_q        <= '{default: '0};
            y_q        <= '{default: '0};
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            load_arr_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            r_q        <= r_d;
            c_q        <= c_d;
            w_q        <= w_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            load_arr_q <= load_arr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
        end
    end

    assign TX_DATA   = tx_data_q;
    assign TX_VALID  = tx_valid_q;
    assign LOAD_ARR  = load_arr_q;
    assign MULT_DONE = done_q;
    assign BUSY      = busy_q;
    assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_nc_mvm_engine.sv
// Bench for nc_mvm_engine: two instances (SHIFT=0 and SHIFT=2) share one stimulus stream
// and are checked against an arithmetic model of the matrix-vector product.
module tb_nc_mvm_engine;
    import nc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready = 1'b1;
    logic       ready_force = 1'b1;
    logic       rand_ready = 1'b0;

    logic [7:0] tx_data0, tx_data2;
    logic       tx_valid0, tx_valid2, load_arr0, load_arr2;
    logic       done0, done2, busy0, busy2, ovr0, ovr2;

    int n_checks = 0;
    int n_fail   = 0;

    int         mw [4];
    int         mx [2];
    logic [7:0] ly0 [2];
    logic [7:0] ly2 [2];
    logic [7:0] exp0 [$];
    logic [7:0] exp2 [$];

    logic       pv [2];
    logic       pr [2];
    logic [7:0] pd [2];

    always #5 clk = ~clk;

    nc_mvm_engine #(.DIM(2), .SHIFT(0)) dut0 (
        .CLK(clk), .RESET(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid),
        .TX_DATA(tx_data0), .TX_VALID(tx_valid0), .TX_READY(tx_ready),
        .LOAD_ARR(load_arr0), .MULT_DONE(done0), .BUSY(busy0), .OVERRUN(ovr0)
    );

    nc_mvm_engine #(.DIM(2), .SHIFT(2)) dut2 (
        .CLK(clk), .RESET(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid),
        .TX_DATA(tx_data2), .TX_VALID(tx_valid2), .TX_READY(tx_ready),
        .LOAD_ARR(load_arr2), .MULT_DONE(done2), .BUSY(busy2), .OVERRUN(ovr2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int to_int(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    // Row result: dot product, arithmetic shift, optional ReLU, clamp to a signed byte.
    function automatic int model_y(input int r, input int sh);
        int s = 0;
        for (int c = 0; c < 2; c++) s += mw[r*2+c] * mx[c];
        s = s >>> sh;
`ifdef NC_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    // Ready driver: fixed level or random per cycle.
    always @(posedge clk) begin
        #2;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic mon(input int id, input logic v, input logic [7:0] d);
        logic [7:0] e;
        if (pv[id] && !pr[id]) begin
            chk($sformatf("tx_hold_valid%0d", id), 32'(v), 32'd1);
            chk($sformatf("tx_hold_data%0d", id), 32'(d), 32'(pd[id]));
        end
        if (v && tx_ready) begin
            if ((id == 0 && exp0.size() == 0) || (id == 1 && exp2.size() == 0)) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected%0d: got byte 0x%0h, expected no transfer", id, d);
            end else begin
                e = (id == 0) ? exp0.pop_front() : exp2.pop_front();
                chk($sformatf("tx_data%0d", id), 32'(d), 32'(e));
            end
        end
        pv[id] = v;
        pr[id] = tx_ready;
        pd[id] = d;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pv[0] = 1'b0;
            pv[1] = 1'b0;
        end else begin
            mon(0, tx_valid0, tx_data0);
            mon(1, tx_valid2, tx_data2);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic load_w(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3);
        send_byte(CMD_LOAD_W);
        chk("load_w_load_arr", 32'(load_arr0), 32'd1);
        chk("load_w_busy", 32'(busy0), 32'd1);
        send_byte(w0); send_byte(w1); send_byte(w2); send_byte(w3);
        mw[0] = to_int(w0); mw[1] = to_int(w1); mw[2] = to_int(w2); mw[3] = to_int(w3);
        chk("load_w_idle", 32'(busy0), 32'd0);
        chk("load_w_arr_low", 32'(load_arr2), 32'd0);
    endtask

    // Checks MULT_DONE stays low for DIM*DIM compute cycles then pulses with TX_VALID.
    task automatic expect_done(input bit inject);
        for (int i = 0; i < 4; i++) begin
            chk("done_early", 32'({done0, done2}), 32'd0);
            chk("compute_busy", 32'({busy0, load_arr0}), 32'b10);
            if (inject && i == 1) begin
                rx_data  = CMD_LOAD_W;
                rx_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
        chk("done_pulse", 32'({done0, done2}), 32'b11);
        chk("first_tx_valid", 32'({tx_valid0, tx_valid2}), 32'b11);
    endtask

    task automatic load_x(input logic [7:0] x0, input logic [7:0] x1, input bit inject);
        send_byte(CMD_LOAD_X);
        chk("load_x_load_arr", 32'(load_arr0), 32'd1);
        send_byte(x0);
        mx[0] = to_int(x0);
        mx[1] = to_int(x1);
        for (int r = 0; r < 2; r++) begin
            ly0[r] = 8'(model_y(r, 0));
            ly2[r] = 8'(model_y(r, 2));
            exp0.push_back(ly0[r]);
            exp2.push_back(ly2[r]);
        end
        send_byte(x1);
        expect_done(inject);
    endtask

    task automatic resend();
        for (int r = 0; r < 2; r++) begin
            exp0.push_back(ly0[r]);
            exp2.push_back(ly2[r]);
        end
        send_byte(CMD_SEND);
        chk("resend_busy", 32'(busy0), 32'd1);
        chk("resend_valid", 32'(tx_valid2), 32'd1);
        chk("resend_ovr_clr", 32'({ovr0, ovr2}), 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy0 || busy2); i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_reached", 32'({busy0, busy2}), 32'd0);
        chk("tx_valid_idle", 32'({tx_valid0, tx_valid2}), 32'd0);
        chk("exp_drained", 32'(exp0.size() + exp2.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tx_data"}, 32'({tx_data0, tx_data2}), 32'd0);
        chk({tag, "_tx_valid"}, 32'({tx_valid0, tx_valid2}), 32'd0);
        chk({tag, "_load_arr"}, 32'({load_arr0, load_arr2}), 32'd0);
        chk({tag, "_done"}, 32'({done0, done2}), 32'd0);
        chk({tag, "_busy"}, 32'({busy0, busy2}), 32'd0);
        chk({tag, "_ovr"}, 32'({ovr0, ovr2}), 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mw[i] = 0;
        for (int i = 0; i < 2; i++) begin
            mx[i]  = 0;
            ly0[i] = 8'h00;
            ly2[i] = 8'h00;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Basic product, model pinned to hand values.
        load_w(8'h01, 8'h02, 8'h03, 8'h04);
        load_x(8'h05, 8'h06, 1'b0);
        chk("pin_y0_s0", 32'(ly0[0]), 32'h11);
        chk("pin_y1_s0", 32'(ly0[1]), 32'h27);
        chk("pin_y0_s2", 32'(ly2[0]), 32'h04);
        chk("pin_y1_s2", 32'(ly2[1]), 32'h09);
        wait_idle();

        // Back-pressure: result held while TX_READY is low.
        ready_force = 1'b0;
        load_x(8'h05, 8'h06, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_data0", 32'(tx_data0), 32'h11);
            chk("stall_data2", 32'(tx_data2), 32'h04);
            chk("stall_valid", 32'(tx_valid0), 32'd1);
            @(posedge clk);
            #1;
        end
        ready_force = 1'b1;
        wait_idle();

        // Saturation in both directions.
        load_w(8'h7f, 8'h7f, 8'h80, 8'h80);
        load_x(8'h7f, 8'h7f, 1'b0);
        chk("pin_sat_hi", 32'(ly0[0]), 32'h7f);
`ifdef NC_RELU_EN
        chk("pin_sat_lo", 32'(ly0[1]), 32'h00);
`else
        chk("pin_sat_lo", 32'(ly0[1]), 32'h80);
`endif
        wait_idle();

        // Shifted results then resend.
        load_w(8'h01, 8'h02, 8'h03, 8'h04);
        load_x(8'h05, 8'h06, 1'b0);
        wait_idle();
        resend();
        wait_idle();

        // Overrun during compute; results unaffected, next command clears it.
        load_x(8'h05, 8'h06, 1'b1);
        chk("overrun_set", 32'({ovr0, ovr2}), 32'b11);
        wait_idle();
        chk("overrun_sticky", 32'(ovr0), 32'd1);
        resend();
        wait_idle();

        // Reset mid-load clears everything; stray byte in IDLE ignored.
        send_byte(CMD_LOAD_W);
        send_byte(8'h33);
        send_byte(8'h44);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("midload_reset");
        rst = 1'b0;
        model_reset();
        send_byte(8'h55);
        chk("ignored_byte_busy", 32'({busy0, busy2}), 32'd0);
        resend();
        wait_idle();

        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int it = 0; it < 24; it++) begin
            op = (it == 0) ? 0 : int'($urandom_range(0, 4));
            case (op)
                0: begin
                    load_w(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                    load_x(8'($urandom), 8'($urandom), 1'b0);
                end
                1, 2: load_x(8'($urandom), 8'($urandom), 1'b0);
                3: resend();
                default: begin
                    send_byte(8'($urandom_range(4, 255)));
                    chk("bogus_cmd_busy", 32'(busy0), 32'd0);
                end
            endcase
            wait_idle();
        end
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
